// File: rtl/adder_result_buffer_if.sv
// Handshake bundle between the pipelined 64-bit adder, adder_result_buffer and its consumer.
// ADDER_RESULT_PARITY_EN adds the out_par signal.
interface adder_result_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic          in_valid;
    logic          in_ready;
    logic [63:0]   sum_i;
    logic          c_i;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_sum;
    logic          out_c;
    logic [AW:0]   count;
`ifdef ADDER_RESULT_PARITY_EN
    logic          out_par;
`endif

    modport slave (
        input  in_valid, sum_i, c_i, out_ready,
        output in_ready, out_valid, out_sum, out_c, count
`ifdef ADDER_RESULT_PARITY_EN
        , output out_par
`endif
    );

    modport master (
        output in_valid, sum_i, c_i, out_ready,
        input  in_ready, out_valid, out_sum, out_c, count
`ifdef ADDER_RESULT_PARITY_EN
        , input out_par
`endif
    );
endinterface

// File: rtl/adder_result_buffer.sv
// Delay-matches launch valids through the fixed-latency adder and queues {carry, sum} in a FWFT FIFO.
// Optional ADDER_RESULT_PARITY_EN stores an even-parity bit per entry and drives out_par.
module adder_result_buffer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input logic                  CLK,
    input logic                  RST_n,
    adder_result_buffer_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int IFW = $clog2(LATENCY + 1);
`ifdef ADDER_RESULT_PARITY_EN
    localparam int EW  = 66;
`else
    localparam int EW  = 65;
`endif

    logic [LATENCY-1:0] vld_pipe;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count_q;
    logic [EW-1:0]      mem [DEPTH];
    logic [IFW-1:0]     inflight;
    logic [EW-1:0]      wr_data;
    logic [EW-1:0]      head;
    logic               ready;
    logic               acc;
    logic               wr_en;
    logic               pop;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++)
            inflight = inflight + IFW'(vld_pipe[i]);
    end

    // Credit counts stored plus in-flight results; a same-cycle pop is deliberately not credited.
    assign ready = (32'(count_q) + 32'(inflight)) < 32'(DEPTH);
    assign acc   = bus.in_valid & ready;
    assign wr_en = vld_pipe[LATENCY-1];
    assign pop   = (count_q != '0) & bus.out_ready;

`ifdef ADDER_RESULT_PARITY_EN
    assign wr_data = {^{bus.c_i, bus.sum_i}, bus.c_i, bus.sum_i};
`else
    assign wr_data = {bus.c_i, bus.sum_i};
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            vld_pipe[0] <= acc;
            for (int unsigned i = 1; i < LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head          = mem[rd_ptr];
    assign bus.in_ready  = ready;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_sum   = head[63:0];
    assign bus.out_c     = head[64];
    assign bus.count     = count_q;
`ifdef ADDER_RESULT_PARITY_EN
    assign bus.out_par   = head[65];
`endif
endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed bench for adder_result_buffer: a 2-stage adder model feeds sum_i/c_i, a queue scoreboards results.
module tb_adder_result_buffer;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 2;

    logic        CLK;
    logic        RST_n;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [64:0] st1;
    logic [64:0] st2;
    logic        tb_acc;
    logic [LATENCY-1:0] tb_vp;
    logic [64:0] sb[$];
    int          checks;
    int          errors;
    int          accepts;
    int          pops;

    adder_result_buffer_if #(.DEPTH(DEPTH)) bus ();

    adder_result_buffer #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Adder model: operands registered at launch, sum valid LATENCY cycles later.
    always @(posedge CLK) begin
        st1 <= {1'b0, op_a} + {1'b0, op_b};
        st2 <= st1;
    end
    assign bus.sum_i = st2[63:0];
    assign bus.c_i   = st2[64];

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) tb_vp <= '0;
        else        tb_vp <= {tb_vp[LATENCY-2:0], tb_acc};
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle from a negedge: scoreboard pop/compare, launch push, write-while-full check.
    task automatic cycle(input logic v, input logic [63:0] a, input logic [63:0] b, input logic ordy);
        logic [64:0] e;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        op_a = a;
        op_b = b;
        if (bus.out_valid && ordy) begin
            pops++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 65'd1, 65'd0);
            end else begin
                e = sb.pop_front();
                chk("data", {bus.out_c, bus.out_sum}, e);
`ifdef ADDER_RESULT_PARITY_EN
                chk("parity", 65'(bus.out_par), 65'(^e));
`endif
            end
        end
        if (RST_n && tb_vp[LATENCY-1])
            chk("no_wr_full", 65'((bus.count == DEPTH) && !(bus.out_valid && ordy)), 65'd0);
        tb_acc = v & bus.in_ready;
        if (tb_acc) begin
            sb.push_back({1'b0, a} + {1'b0, b});
            accepts++;
        end
        @(negedge CLK);
    endtask

    initial begin
        int base;
        checks = 0; errors = 0; accepts = 0; pops = 0;
        RST_n = 1'b0;
        tb_acc = 1'b0;
        op_a = '0;
        op_b = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_in_valid_out", 65'(bus.out_valid), 65'd0);
        chk("rst_in_count", 65'(bus.count), 65'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        chk("rst_out_valid", 65'(bus.out_valid), 65'd0);
        chk("rst_out_sum", 65'(bus.out_sum), 65'd0);
        chk("rst_out_c", 65'(bus.out_c), 65'd0);
        chk("rst_count", 65'(bus.count), 65'd0);
        chk("rst_in_ready", 65'(bus.in_ready), 65'd1);

        // Single launch, latency LATENCY+1 into an empty FIFO
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        chk("lat_t1_valid", 65'(bus.out_valid), 65'd0);
        cycle(1'b0, '0, '0, 1'b1);
        chk("lat_t2_valid", 65'(bus.out_valid), 65'd0);
        cycle(1'b0, '0, '0, 1'b1);
        chk("lat_t3_valid", 65'(bus.out_valid), 65'd1);
        chk("lat_t3_sum", 65'(bus.out_sum), 65'd0);
        chk("lat_t3_c", 65'(bus.out_c), 65'd1);
        cycle(1'b0, '0, '0, 1'b1);
        chk("lat_t4_valid", 65'(bus.out_valid), 65'd0);

        // Back-to-back launches with consumer stalled: only DEPTH accepted
        base = accepts;
        for (int i = 0; i < 10; i++) begin
            chk("fill_in_ready", 65'(bus.in_ready), 65'(i < 4));
            cycle(1'b1, 64'(i), 64'(i), 1'b0);
        end
        chk("fill_accepts", 65'(accepts - base), 65'd4);
        cycle(1'b0, '0, '0, 1'b0);
        chk("fill_count", 65'(bus.count), 65'd4);
        chk("fill_ready_low", 65'(bus.in_ready), 65'd0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_sum", 65'(bus.out_sum), 65'(2 * k));
            cycle(1'b0, '0, '0, 1'b1);
        end
        chk("drain_count", 65'(bus.count), 65'd0);

        // Continuous launch with carry across bit 32
        base = pops;
        for (int i = 0; i < 20; i++) begin
            chk("stream_in_ready", 65'(bus.in_ready), 65'd1);
            chk("stream_count_le1", 65'(bus.count <= 1), 65'd1);
            if (i >= 3) chk("stream_valid", 65'(bus.out_valid), 65'd1);
            cycle(1'b1, {(i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0, 32'h8000_0000 + 32'(i)},
                  64'h0000_0000_8000_0000, 1'b1);
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b1);
        chk("stream_pops", 65'(pops - base), 65'd20);
        chk("stream_sb_empty", 65'(sb.size()), 65'd0);

        // Deepest reachable occupancy at write time with a simultaneous pop
        for (int i = 0; i < 4; i++) begin
            chk("pp_in_ready", 65'(bus.in_ready), 65'd1);
            cycle(1'b1, 64'hF000_0000_0000_0000 + 64'(i), 64'h2000_0000_0000_0000, 1'b0);
        end
        cycle(1'b0, '0, '0, 1'b0);
        chk("pp_count_before", 65'(bus.count), 65'd3);
        cycle(1'b0, '0, '0, 1'b1);
        chk("pp_count_after", 65'(bus.count), 65'd3);
        chk("pp_head", {bus.out_c, bus.out_sum}, 65'h1_1000_0000_0000_0001);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0, 1'b1);
        chk("pp_count_end", 65'(bus.count), 65'd0);
        chk("pp_sb_empty", 65'(sb.size()), 65'd0);

        // Reset with results stored and in flight
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(i + 40), 64'd1, 1'b0);
        chk("mr_count_pre", 65'(bus.count), 65'd2);
        RST_n = 1'b0;
        #1;
        chk("mr_out_valid", 65'(bus.out_valid), 65'd0);
        chk("mr_count", 65'(bus.count), 65'd0);
        chk("mr_in_ready", 65'(bus.in_ready), 65'd1);
        bus.in_valid = 1'b0;
        tb_acc = 1'b0;
        sb.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("mr_no_stale", 65'(bus.out_valid), 65'd0);
            chk("mr_ready", 65'(bus.in_ready), 65'd1);
            cycle(1'b0, '0, '0, 1'b1);
        end
        cycle(1'b1, 64'd5, 64'd7, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        chk("post_valid", 65'(bus.out_valid), 65'd1);
        chk("post_sum", 65'(bus.out_sum), 65'd12);
        cycle(1'b0, '0, '0, 1'b1);
        chk("post_sb_empty", 65'(sb.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
